// File: rtl/hps_bridge_mm.sv
// hps_bridge_mm: Avalon-MM slave between the HPS and the modem TX/RX byte
// FIFOs, navigation timer and receiver tuning registers. Provides a maskable
// W1C interrupt pending register and a small sequencer that auto-replies to
// navigation queries or issues a navigation start, sharing the TX port with
// the host through waitrequest.
module hps_bridge_mm #(
  parameter int unsigned DATA_W       = 8,
  parameter int unsigned CNT_W        = 8,
  parameter int unsigned NUM_IRQ      = 4,
  parameter int unsigned NQ_SRC       = 3,
  parameter logic [7:0]  REPLY_CODE   = 8'h02,
  parameter logic [7:0]  QUERY_CODE   = 8'h04,
  parameter int unsigned RX_THR_DEF   = 600,
  parameter int unsigned COMP_THR_DEF = 6,
  parameter logic [31:0] VERSION      = 32'h0002_0000
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [7:0]         address,
  input  logic               chipselect,
  input  logic               read,
  input  logic               write,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic               readdatavalid,
  output logic               waitrequest,
  output logic [DATA_W-1:0]  data_tx,
  output logic [CNT_W-1:0]   size_fifo_tx,
  output logic               wren_fifo_tx,
  output logic               start_tx,
  input  logic               ready_tx,
  input  logic [DATA_W-1:0]  data_rx,
  input  logic [CNT_W-1:0]   size_fifo_rx,
  output logic               rden_fifo_rx,
  input  logic [NUM_IRQ-1:0] irq_event,
  output logic               irq,
  output logic               navig_timer_start,
  output logic [31:0]        rx_threshold,
  output logic [31:0]        comp_threshold,
  output logic [31:0]        guard_interval,
  output logic [31:0]        mem_addr,
  input  logic [31:0]        end_address
);

  localparam logic [7:0] A_TX_SIZE  = 8'h00;
  localparam logic [7:0] A_TX_DATA  = 8'h04;
  localparam logic [7:0] A_TX_START = 8'h08;
  localparam logic [7:0] A_STATUS   = 8'h0C;
  localparam logic [7:0] A_RX_DATA  = 8'h10;
  localparam logic [7:0] A_PEND     = 8'h14;
  localparam logic [7:0] A_MASK     = 8'h18;
  localparam logic [7:0] A_NAVIG    = 8'h1C;
  localparam logic [7:0] A_RX_THR   = 8'h20;
  localparam logic [7:0] A_COMP_THR = 8'h24;
  localparam logic [7:0] A_GUARD    = 8'h28;
  localparam logic [7:0] A_MEM_ADDR = 8'h2C;
  localparam logic [7:0] A_END_ADDR = 8'h30;
  localparam logic [7:0] A_ID       = 8'h34;

  typedef enum logic [2:0] {IDLE, AR_PUSH, AR_START, NS_PUSH, NS_START} state_t;

  state_t             state, state_next;
  logic               reply_req;
  logic               unf, ovf;
  logic [NUM_IRQ-1:0] pend, mask, pend_clr;
  logic [31:0]        rdata;
  logic               rd_en, wr_en, wr_acc, tx_addr, busy, rx_nempty, q_evt;

  assign rd_en     = chipselect & read;
  // A simultaneous read wins; the write half is dropped.
  assign wr_en     = chipselect & write & ~read;
  assign tx_addr   = (address == A_TX_SIZE) | (address == A_TX_DATA) |
                     (address == A_TX_START) | (address == A_NAVIG);
  assign busy      = (state != IDLE) | reply_req;
  assign waitrequest = chipselect & write & tx_addr & busy;
  assign wr_acc    = wr_en & ~waitrequest;
  assign rx_nempty = (size_fifo_rx != '0);
  assign q_evt     = irq_event[NQ_SRC];
  // Show-ahead FIFO: pop on the same cycle the head is captured into readdata.
  assign rden_fifo_rx = rd_en & (address == A_RX_DATA) & rx_nempty;
  assign pend_clr  = (wr_acc && address == A_PEND) ? writedata[NUM_IRQ-1:0] : '0;

  // Sequencer state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  // Sequencer next state; a pending reply is served before a NAVIG_START.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (reply_req)                        state_next = AR_PUSH;
        else if (wr_acc && address == A_NAVIG) state_next = NS_PUSH;
      end
      AR_PUSH:  state_next = AR_START;
      AR_START: state_next = IDLE;
      NS_PUSH:  state_next = NS_START;
      NS_START: state_next = IDLE;
      default:  state_next = IDLE;
    endcase
  end

  // TX port outputs, registered; the sequencer loads them on entering each state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_tx           <= '0;
      size_fifo_tx      <= '0;
      wren_fifo_tx      <= 1'b0;
      start_tx          <= 1'b0;
      navig_timer_start <= 1'b0;
    end else begin
      wren_fifo_tx      <= 1'b0;
      start_tx          <= 1'b0;
      navig_timer_start <= 1'b0;
      if (wr_acc && address == A_TX_SIZE) size_fifo_tx <= writedata[CNT_W-1:0];
      if (wr_acc && address == A_TX_DATA) begin
        data_tx      <= writedata[DATA_W-1:0];
        wren_fifo_tx <= 1'b1;
      end
      if (wr_acc && address == A_TX_START) start_tx <= 1'b1;
      case (state_next)
        AR_PUSH: begin
          data_tx      <= DATA_W'(REPLY_CODE);
          size_fifo_tx <= CNT_W'(1);
          wren_fifo_tx <= 1'b1;
        end
        NS_PUSH: begin
          data_tx      <= DATA_W'(QUERY_CODE);
          size_fifo_tx <= CNT_W'(1);
          wren_fifo_tx <= 1'b1;
        end
        AR_START: start_tx <= 1'b1;
        NS_START: begin
          start_tx          <= 1'b1;
          navig_timer_start <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Reply request and sticky status flags; a query while one is pending is dropped.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      reply_req <= 1'b0;
      unf       <= 1'b0;
      ovf       <= 1'b0;
    end else begin
      if (state == AR_START) reply_req <= 1'b0;
      if (q_evt && !reply_req) reply_req <= 1'b1;
      if (wr_acc && address == A_STATUS && writedata[2]) unf <= 1'b0;
      if (rd_en && address == A_RX_DATA && !rx_nempty)   unf <= 1'b1;
      if (wr_acc && address == A_STATUS && writedata[3]) ovf <= 1'b0;
      if (q_evt && reply_req)                            ovf <= 1'b1;
    end
  end

  // Interrupt pending (set beats W1C), mask and registered irq level.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend <= '0;
      mask <= '0;
      irq  <= 1'b0;
    end else begin
      pend <= (pend & ~pend_clr) | irq_event;
      if (wr_acc && address == A_MASK) mask <= writedata[NUM_IRQ-1:0];
      irq  <= |(pend & mask);
    end
  end

  // Tuning and DMA registers; a zero write restores the threshold defaults.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_threshold   <= 32'(RX_THR_DEF);
      comp_threshold <= 32'(COMP_THR_DEF);
      guard_interval <= '0;
      mem_addr       <= '0;
    end else if (wr_acc) begin
      case (address)
        A_RX_THR:   rx_threshold   <= (writedata == '0) ? 32'(RX_THR_DEF) : writedata;
        A_COMP_THR: comp_threshold <= (writedata == '0) ? 32'(COMP_THR_DEF) : writedata;
        A_GUARD:    guard_interval <= writedata;
        A_MEM_ADDR: mem_addr       <= writedata;
        default: ;
      endcase
    end
  end

  // Read data multiplexer.
  always_comb begin
    rdata = '0;
    case (address)
      A_TX_SIZE:  rdata = 32'(size_fifo_tx);
      A_STATUS:   rdata = {16'(size_fifo_rx), 12'd0, ovf, unf, rx_nempty, ready_tx};
      A_RX_DATA:  rdata = rx_nempty ? 32'(data_rx) : '0;
      A_PEND:     rdata = 32'(pend);
      A_MASK:     rdata = 32'(mask);
      A_RX_THR:   rdata = rx_threshold;
      A_COMP_THR: rdata = comp_threshold;
      A_GUARD:    rdata = guard_interval;
      A_MEM_ADDR: rdata = mem_addr;
      A_END_ADDR: rdata = end_address;
      A_ID:       rdata = VERSION;
      default:    rdata = '0;
    endcase
  end

  // Registered read response, one cycle after the read is sampled.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= rd_en;
      if (rd_en) readdata <= rdata;
    end
  end

endmodule

// File: tb/tb_hps_bridge_mm.sv
// Directed self-checking bench for hps_bridge_mm.
module tb_hps_bridge_mm;

  logic        clk;
  logic        reset_n;
  logic [7:0]  address;
  logic        chipselect, read, write;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic        readdatavalid, waitrequest;
  logic [7:0]  data_tx;
  logic [7:0]  size_fifo_tx;
  logic        wren_fifo_tx, start_tx, ready_tx;
  logic [7:0]  data_rx;
  logic [7:0]  size_fifo_rx;
  logic        rden_fifo_rx;
  logic [3:0]  irq_event;
  logic        irq, navig_timer_start;
  logic [31:0] rx_threshold, comp_threshold, guard_interval, mem_addr, end_address;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;

  // RX FIFO model: show-ahead head, count = loaded - popped
  logic [7:0] rx_mem [4];
  logic [7:0] rx_load;
  logic [7:0] pops = 8'd0;
  assign data_rx      = rx_mem[pops[1:0]];
  assign size_fifo_rx = rx_load - pops;
  always @(posedge clk) if (rden_fifo_rx) pops <= pops + 8'd1;

  hps_bridge_mm #(
    .DATA_W(8), .CNT_W(8), .NUM_IRQ(4), .NQ_SRC(3),
    .REPLY_CODE(8'h02), .QUERY_CODE(8'h04),
    .RX_THR_DEF(600), .COMP_THR_DEF(6), .VERSION(32'h0002_0000)
  ) dut (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(chipselect),
    .read(read), .write(write), .writedata(writedata), .readdata(readdata),
    .readdatavalid(readdatavalid), .waitrequest(waitrequest),
    .data_tx(data_tx), .size_fifo_tx(size_fifo_tx), .wren_fifo_tx(wren_fifo_tx),
    .start_tx(start_tx), .ready_tx(ready_tx), .data_rx(data_rx),
    .size_fifo_rx(size_fifo_rx), .rden_fifo_rx(rden_fifo_rx),
    .irq_event(irq_event), .irq(irq), .navig_timer_start(navig_timer_start),
    .rx_threshold(rx_threshold), .comp_threshold(comp_threshold),
    .guard_interval(guard_interval), .mem_addr(mem_addr), .end_address(end_address)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_wr(input logic [7:0] a, input logic [31:0] d);
    int unsigned n;
    n = 0;
    chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
    #1;
    while (waitrequest && n < 16) begin
      tick();
      n++;
    end
    chk("wr_wait_bound", 32'(n < 16), 32'd1);
    tick();
    chipselect = 1'b0; write = 1'b0;
  endtask

  task automatic bus_rd(input logic [7:0] a, output logic [31:0] d);
    chipselect = 1'b1; read = 1'b1; address = a;
    tick();
    chipselect = 1'b0; read = 1'b0;
    chk("rd_valid", 32'(readdatavalid), 32'd1);
    d = readdata;
  endtask

  initial begin
    logic [31:0] rv;
    reset_n = 1'b0; address = '0; chipselect = 1'b0; read = 1'b0; write = 1'b0;
    writedata = '0; ready_tx = 1'b1; irq_event = '0; end_address = 32'hDEAD_BEEF;
    rx_load = 8'd0;
    rx_mem[0] = 8'h55; rx_mem[1] = 8'h66; rx_mem[2] = 8'h77; rx_mem[3] = 8'h88;
    tick(); tick(); tick();

    // ---- reset state
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_rdvalid", 32'(readdatavalid), 32'd0);
    chk("rst_wait", 32'(waitrequest), 32'd0);
    chk("rst_wren", 32'(wren_fifo_tx), 32'd0);
    chk("rst_start", 32'(start_tx), 32'd0);
    chk("rst_rden", 32'(rden_fifo_rx), 32'd0);
    chk("rst_nav", 32'(navig_timer_start), 32'd0);
    chk("rst_irq", 32'(irq), 32'd0);
    chk("rst_data_tx", 32'(data_tx), 32'd0);
    chk("rst_size_tx", 32'(size_fifo_tx), 32'd0);
    chk("rst_rx_thr", rx_threshold, 32'd600);
    chk("rst_comp_thr", comp_threshold, 32'd6);
    chk("rst_guard", guard_interval, 32'd0);
    chk("rst_mem", mem_addr, 32'd0);
    reset_n = 1'b1;
    tick();

    // ---- registers
    bus_rd(8'h20, rv); chk("rd_rx_thr", rv, 32'd600);
    bus_rd(8'h24, rv); chk("rd_comp_thr", rv, 32'd6);
    bus_rd(8'h34, rv); chk("rd_id", rv, 32'h0002_0000);
    bus_wr(8'h20, 32'd0);    bus_rd(8'h20, rv); chk("rx_thr_zero", rv, 32'd600);
    bus_wr(8'h20, 32'd1234); bus_rd(8'h20, rv); chk("rx_thr_1234", rv, 32'd1234);
    chk("rx_thr_port", rx_threshold, 32'd1234);
    bus_wr(8'h24, 32'd0);    bus_rd(8'h24, rv); chk("comp_thr_zero", rv, 32'd6);
    bus_wr(8'h28, 32'h1357_9BDF); chk("guard_port", guard_interval, 32'h1357_9BDF);
    bus_wr(8'h2C, 32'h8000_0040); bus_rd(8'h2C, rv); chk("rd_mem", rv, 32'h8000_0040);
    bus_rd(8'h30, rv); chk("rd_end", rv, 32'hDEAD_BEEF);
    bus_rd(8'h38, rv); chk("rd_unmapped", rv, 32'd0);
    tick();
    chk("rdvalid_drop", 32'(readdatavalid), 32'd0);

    // ---- TX path: size, three back-to-back bytes, start
    bus_wr(8'h00, 32'h0000_0103);
    chk("tx_size", 32'(size_fifo_tx), 32'd3);
    chipselect = 1'b1; write = 1'b1; address = 8'h04; writedata = 32'hA1;
    tick(); chk("tx_wren1", 32'(wren_fifo_tx), 32'd1); chk("tx_data1", 32'(data_tx), 32'hA1);
    writedata = 32'hA2;
    tick(); chk("tx_wren2", 32'(wren_fifo_tx), 32'd1); chk("tx_data2", 32'(data_tx), 32'hA2);
    writedata = 32'hA3;
    tick(); chk("tx_wren3", 32'(wren_fifo_tx), 32'd1); chk("tx_data3", 32'(data_tx), 32'hA3);
    address = 8'h08;
    tick(); chk("tx_wren_off", 32'(wren_fifo_tx), 32'd0); chk("tx_start", 32'(start_tx), 32'd1);
    chipselect = 1'b0; write = 1'b0;
    tick(); chk("tx_start_off", 32'(start_tx), 32'd0);
    bus_rd(8'h00, rv); chk("rd_tx_size", rv, 32'd3);

    // ---- RX path: two bytes, then an underflowing read
    rx_load = 8'd2;
    bus_rd(8'h0C, rv); chk("status_rx2", rv, 32'h0002_0003);
    chipselect = 1'b1; read = 1'b1; address = 8'h10; #1;
    chk("rx_pop1", 32'(rden_fifo_rx), 32'd1);
    tick(); chipselect = 1'b0; read = 1'b0;
    chk("rx_data1", readdata, 32'h55);
    chipselect = 1'b1; read = 1'b1; #1;
    chk("rx_pop2", 32'(rden_fifo_rx), 32'd1);
    tick(); chipselect = 1'b0; read = 1'b0;
    chk("rx_data2", readdata, 32'h66);
    chipselect = 1'b1; read = 1'b1; #1;
    chk("rx_pop3_none", 32'(rden_fifo_rx), 32'd0);
    tick(); chipselect = 1'b0; read = 1'b0;
    chk("rx_data3", readdata, 32'd0);
    chk("rx_pops", 32'(pops), 32'd2);
    bus_rd(8'h0C, rv); chk("status_unf", rv, 32'h0000_0005);
    bus_wr(8'h0C, 32'h4); bus_rd(8'h0C, rv); chk("status_unf_clr", rv, 32'h0000_0001);

    // ---- interrupts
    bus_wr(8'h18, 32'hFFFF_FFF5);
    bus_rd(8'h18, rv); chk("mask", rv, 32'h5);
    irq_event = 4'b0011;
    tick(); irq_event = '0;
    chk("irq_lat1", 32'(irq), 32'd0);
    tick(); chk("irq_lat2", 32'(irq), 32'd1);
    bus_rd(8'h14, rv); chk("pend_set", rv, 32'h3);
    chipselect = 1'b1; write = 1'b1; address = 8'h14; writedata = 32'h1;
    tick(); chipselect = 1'b0; write = 1'b0;
    chk("irq_fall1", 32'(irq), 32'd1);
    tick(); chk("irq_fall2", 32'(irq), 32'd0);
    bus_rd(8'h14, rv); chk("pend_w1c", rv, 32'h2);
    chipselect = 1'b1; write = 1'b1; address = 8'h14; writedata = 32'h1; irq_event = 4'b0001;
    tick(); chipselect = 1'b0; write = 1'b0; irq_event = '0;
    bus_rd(8'h14, rv); chk("pend_set_wins", rv, 32'h3);
    bus_wr(8'h14, 32'hF);
    bus_rd(8'h14, rv); chk("pend_clr_all", rv, 32'h0);

    // ---- auto-reply arbitrated against a host TX write
    irq_event = 4'b1000;
    tick();
    irq_event = '0;
    chipselect = 1'b1; write = 1'b1; address = 8'h04; writedata = 32'hB7; #1;
    chk("ar_wait1", 32'(waitrequest), 32'd1);
    chk("ar_wren_n1", 32'(wren_fifo_tx), 32'd0);
    tick();
    chk("ar_wait2", 32'(waitrequest), 32'd1);
    chk("ar_wren", 32'(wren_fifo_tx), 32'd1);
    chk("ar_data", 32'(data_tx), 32'h02);
    chk("ar_size", 32'(size_fifo_tx), 32'd1);
    irq_event = 4'b1000;
    tick();
    irq_event = '0;
    chk("ar_wait3", 32'(waitrequest), 32'd1);
    chk("ar_start", 32'(start_tx), 32'd1);
    chk("ar_wren_off", 32'(wren_fifo_tx), 32'd0);
    tick();
    chk("ar_wait_rel", 32'(waitrequest), 32'd0);
    chk("ar_start_off", 32'(start_tx), 32'd0);
    tick();
    chipselect = 1'b0; write = 1'b0;
    chk("ar_host_wren", 32'(wren_fifo_tx), 32'd1);
    chk("ar_host_data", 32'(data_tx), 32'hB7);
    tick();
    chk("ar_no_second_wren", 32'(wren_fifo_tx), 32'd0);
    tick();
    chk("ar_no_second_start", 32'(start_tx), 32'd0);
    bus_rd(8'h0C, rv); chk("status_ovf", rv, 32'h0000_0009);
    bus_wr(8'h0C, 32'h8); bus_rd(8'h0C, rv); chk("status_ovf_clr", rv, 32'h0000_0001);

    // ---- navigation start
    chipselect = 1'b1; write = 1'b1; address = 8'h1C; writedata = 32'h1; #1;
    chk("ns_wait", 32'(waitrequest), 32'd0);
    tick(); chipselect = 1'b0; write = 1'b0;
    chk("ns_wren", 32'(wren_fifo_tx), 32'd1);
    chk("ns_data", 32'(data_tx), 32'h04);
    chk("ns_size", 32'(size_fifo_tx), 32'd1);
    chk("ns_start_early", 32'(start_tx), 32'd0);
    tick();
    chk("ns_start", 32'(start_tx), 32'd1);
    chk("ns_nav", 32'(navig_timer_start), 32'd1);
    chk("ns_wren_off", 32'(wren_fifo_tx), 32'd0);
    tick();
    chk("ns_start_off", 32'(start_tx), 32'd0);
    chk("ns_nav_off", 32'(navig_timer_start), 32'd0);

    // ---- reset in the middle of a navigation sequence
    chipselect = 1'b1; write = 1'b1; address = 8'h1C; writedata = 32'h1;
    tick(); chipselect = 1'b0; write = 1'b0;
    chk("nr_wren", 32'(wren_fifo_tx), 32'd1);
    reset_n = 1'b0; #1;
    chk("nr_wren_rst", 32'(wren_fifo_tx), 32'd0);
    chk("nr_start_rst", 32'(start_tx), 32'd0);
    chk("nr_nav_rst", 32'(navig_timer_start), 32'd0);
    tick();
    chk("nr_start_hold", 32'(start_tx), 32'd0);
    reset_n = 1'b1;
    tick();
    chk("nr_start_after1", 32'(start_tx), 32'd0);
    chk("nr_nav_after1", 32'(navig_timer_start), 32'd0);
    tick();
    chk("nr_start_after2", 32'(start_tx), 32'd0);
    chk("nr_nav_after2", 32'(navig_timer_start), 32'd0);
    chk("nr_wren_after2", 32'(wren_fifo_tx), 32'd0);
    chipselect = 1'b1; write = 1'b1; address = 8'h04; writedata = 32'hC3; #1;
    chk("nr_idle_wait", 32'(waitrequest), 32'd0);
    tick(); chipselect = 1'b0; write = 1'b0;
    chk("nr_host_wren", 32'(wren_fifo_tx), 32'd1);
    chk("nr_host_data", 32'(data_tx), 32'hC3);
    bus_rd(8'h20, rv); chk("nr_rx_thr_def", rv, 32'd600);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
